tape_player: RTL and testbench



---
 rtl/tape_pkg.sv | 27 ++
 rtl/tape_pulse_timer.sv | 29 ++
 rtl/tape_player.sv | 194 +++++++++++++++++++
 tb/tb_tape_player.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tape_pkg.sv
// rtl/tape_pkg.sv - shared state encoding and ROM-loader timing constants for the tape player
package tape_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH0,
        ST_PILOT,
        ST_SYNC1,
        ST_SYNC2,
        ST_DATA,
        ST_NEXT,
        ST_PAUSE
    } tape_state_t;

    localparam int CNT_W   = 22;
    localparam int PILOT_W = 13;

    localparam int unsigned PILOT_T_DEF   = 2168;
    localparam int unsigned SYNC1_T_DEF   = 667;
    localparam int unsigned SYNC2_T_DEF   = 735;
    localparam int unsigned BIT0_T_DEF    = 855;
    localparam int unsigned BIT1_T_DEF    = 1710;
    localparam int unsigned PILOT_HDR_DEF = 8063;
    localparam int unsigned PILOT_DAT_DEF = 3223;
    localparam int unsigned PAUSE_T_DEF   = 3500000;

endpackage

// File: rtl/tape_pulse_timer.sv
// rtl/tape_pulse_timer.sv - loadable 22-bit T-state down-counter with one-cycle done strobe
module tape_pulse_timer
    import tape_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CE,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    input  logic             hold,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    // The strobe at count 0 ends the pulse; a load on that edge starts the next with no gap.
    assign done = CE & ~hold & (cnt == '0);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= len;
        end else if (CE && !hold && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/tape_player.sv
// rtl/tape_player.sv - TAP block to EAR waveform generator: pilot, syncs, data bits, pause
module tape_player
    import tape_pkg::*;
#(
    parameter int unsigned PILOT_T   = PILOT_T_DEF,
    parameter int unsigned SYNC1_T   = SYNC1_T_DEF,
    parameter int unsigned SYNC2_T   = SYNC2_T_DEF,
    parameter int unsigned BIT0_T    = BIT0_T_DEF,
    parameter int unsigned BIT1_T    = BIT1_T_DEF,
    parameter int unsigned PILOT_HDR = PILOT_HDR_DEF,
    parameter int unsigned PILOT_DAT = PILOT_DAT_DEF,
    parameter int unsigned PAUSE_T   = PAUSE_T_DEF
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CE,
    input  logic       PLAY,
    input  logic [7:0] DIN,
    input  logic       DIN_LAST,
    input  logic       DIN_VALID,
    output logic       DIN_READY,
    output logic       EAR,
    output logic       BUSY
);

    localparam logic [CNT_W-1:0]   L_PILOT = CNT_W'(PILOT_T - 1);
    localparam logic [CNT_W-1:0]   L_SYNC1 = CNT_W'(SYNC1_T - 1);
    localparam logic [CNT_W-1:0]   L_SYNC2 = CNT_W'(SYNC2_T - 1);
    localparam logic [CNT_W-1:0]   L_BIT0  = CNT_W'(BIT0_T - 1);
    localparam logic [CNT_W-1:0]   L_BIT1  = CNT_W'(BIT1_T - 1);
    localparam logic [CNT_W-1:0]   L_PAUSE = CNT_W'(PAUSE_T - 1);
    localparam logic [PILOT_W-1:0] L_PHDR  = PILOT_W'(PILOT_HDR - 1);
    localparam logic [PILOT_W-1:0] L_PDAT  = PILOT_W'(PILOT_DAT - 1);

    tape_state_t        state, state_n;
    logic [7:0]         shift, shift_n;
    logic               last, last_n;
    logic [PILOT_W-1:0] pilot_cnt, pilot_n;
    logic [2:0]         bit_idx, bit_n;
    logic               half, half_n;
    logic               ear, ear_n;
    logic               ready_q, ready_n;
    logic               xfer, ld, hold, done;
    logic [CNT_W-1:0]   ld_len;

    function automatic logic [CNT_W-1:0] bit_len(input logic b);
        return b ? L_BIT1 : L_BIT0;
    endfunction

    tape_pulse_timer u_timer (
        .CLK   (CLK),
        .RESET (RESET),
        .CE    (CE),
        .load  (ld),
        .len   (ld_len),
        .hold  (hold),
        .done  (done)
    );

    assign xfer      = DIN_VALID & ready_q;
    assign DIN_READY = ready_q;
    assign EAR       = ear;
    assign BUSY      = (state != ST_IDLE);

    // PAUSE ignores PLAY so a block always ends in a full silence; handshake states never count.
    assign hold = (state == ST_IDLE) || (state == ST_FETCH0) || (state == ST_NEXT) ||
                  (!PLAY && state != ST_PAUSE);

    always_comb begin
        state_n = state;
        shift_n = shift;
        last_n  = last;
        pilot_n = pilot_cnt;
        bit_n   = bit_idx;
        half_n  = half;
        ear_n   = ear;
        ld      = 1'b0;
        ld_len  = '0;
        case (state)
            ST_IDLE: begin
                if (PLAY) state_n = ST_FETCH0;
            end
            ST_FETCH0: begin
                if (xfer) begin
                    shift_n = DIN;
                    last_n  = DIN_LAST;
                    pilot_n = DIN[7] ? L_PDAT : L_PHDR;
                    ld      = 1'b1;
                    ld_len  = L_PILOT;
                    state_n = ST_PILOT;
                end
            end
            ST_PILOT: begin
                if (done) begin
                    ear_n = ~ear;
                    ld    = 1'b1;
                    if (pilot_cnt == '0) begin
                        ld_len  = L_SYNC1;
                        state_n = ST_SYNC1;
                    end else begin
                        ld_len  = L_PILOT;
                        pilot_n = pilot_cnt - 1'b1;
                    end
                end
            end
            ST_SYNC1: begin
                if (done) begin
                    ear_n   = ~ear;
                    ld      = 1'b1;
                    ld_len  = L_SYNC2;
                    state_n = ST_SYNC2;
                end
            end
            ST_SYNC2: begin
                if (done) begin
                    ear_n   = ~ear;
                    ld      = 1'b1;
                    ld_len  = bit_len(shift[7]);
                    bit_n   = 3'd7;
                    half_n  = 1'b0;
                    state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                if (done) begin
                    if (!half) begin
                        ear_n  = ~ear;
                        half_n = 1'b1;
                        ld     = 1'b1;
                        ld_len = bit_len(shift[7]);
                    end else begin
                        half_n = 1'b0;
                        if (bit_idx == 3'd0) begin
                            if (last) begin
                                ear_n   = 1'b0;
                                ld      = 1'b1;
                                ld_len  = L_PAUSE;
                                state_n = ST_PAUSE;
                            end else begin
                                ear_n   = ~ear;
                                state_n = ST_NEXT;
                            end
                        end else begin
                            ear_n   = ~ear;
                            bit_n   = bit_idx - 1'b1;
                            shift_n = {shift[6:0], 1'b0};
                            ld      = 1'b1;
                            ld_len  = bit_len(shift[6]);
                        end
                    end
                end
            end
            ST_NEXT: begin
                if (xfer) begin
                    shift_n = DIN;
                    last_n  = DIN_LAST;
                    bit_n   = 3'd7;
                    half_n  = 1'b0;
                    ld      = 1'b1;
                    ld_len  = bit_len(DIN[7]);
                    state_n = ST_DATA;
                end
            end
            ST_PAUSE: begin
                if (done) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
        ready_n = PLAY && (state_n == ST_FETCH0 || state_n == ST_NEXT);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= ST_IDLE;
            shift     <= '0;
            last      <= 1'b0;
            pilot_cnt <= '0;
            bit_idx   <= '0;
            half      <= 1'b0;
            ear       <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state     <= state_n;
            shift     <= shift_n;
            last      <= last_n;
            pilot_cnt <= pilot_n;
            bit_idx   <= bit_n;
            half      <= half_n;
            ear       <= ear_n;
            ready_q   <= ready_n;
        end
    end

endmodule

// File: tb/tb_tape_player.sv
// tb/tb_tape_player.sv - table-driven bench for tape_player with shortened pulse timing
module tb_tape_player;

    localparam int P_PILOT = 6;
    localparam int P_SYNC1 = 3;
    localparam int P_SYNC2 = 4;
    localparam int P_BIT0  = 2;
    localparam int P_BIT1  = 5;
    localparam int P_HDR   = 5;
    localparam int P_DAT   = 3;
    localparam int P_PAUSE = 40;
    localparam int TMO     = 20000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce = 1'b0;
    logic       play = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_last = 1'b0;
    logic       din_valid = 1'b0;
    logic       din_ready, ear, busy;

    tape_player #(
        .PILOT_T(P_PILOT), .SYNC1_T(P_SYNC1), .SYNC2_T(P_SYNC2), .BIT0_T(P_BIT0),
        .BIT1_T(P_BIT1), .PILOT_HDR(P_HDR), .PILOT_DAT(P_DAT), .PAUSE_T(P_PAUSE)
    ) dut (
        .CLK(clk), .RESET(rst), .CE(ce), .PLAY(play), .DIN(din), .DIN_LAST(din_last),
        .DIN_VALID(din_valid), .DIN_READY(din_ready), .EAR(ear), .BUSY(busy)
    );

    typedef struct {
        logic [2:0][7:0] b;
        int              nbytes;
        int              exp_pilot;
        int              underrun;
        bit              coincide;
        int              gap_at;
        int              gap_len;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   ce_div = 0;
    int   eff_cnt = 0;
    int   tog_q[$];
    logic ear_prev = 1'b0;
    logic busy_prev = 1'b0;
    bit   busy_fell = 1'b0;
    int   busy_fall_t = 0;
    logic ear_at_fall = 1'b0;
    vec_t vecs[6];

    always #5 clk = ~clk;

    always @(negedge clk) begin
        ce_div = (ce_div + 1) % 4;
        ce     = (ce_div == 0);
    end

    // T-states the block is allowed to count (PLAY high); bench timing reference.
    always @(posedge clk) if (ce && play) eff_cnt <= eff_cnt + 1;

    always @(negedge clk) begin
        if (ear !== ear_prev) tog_q.push_back(eff_cnt);
        if (!busy && busy_prev) begin
            busy_fell   = 1'b1;
            busy_fall_t = eff_cnt;
            ear_at_fall = ear;
        end
        ear_prev  = ear;
        busy_prev = busy;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                input int n, input int p, input int u, input bit c,
                                input int ga, input int gl);
        vec_t v;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2;
        v.nbytes = n; v.exp_pilot = p; v.underrun = u; v.coincide = c;
        v.gap_at = ga; v.gap_len = gl;
        return v;
    endfunction

    task automatic wait_ce(input int n);
        int c = 0;
        while (c < n) begin
            @(negedge clk); #1;
            if (ce) c++;
        end
    endtask

    task automatic wait_ready(output bit ok);
        int i = 0;
        ok = 1'b0;
        while (i < TMO && !din_ready) begin
            @(negedge clk); #1;
            i++;
        end
        ok = din_ready;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL ready_timeout: got DIN_READY=0 after %0d cycles, expected 1", TMO);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   xt[3];
        int   exp_q[$];
        int   t, n, total, exp_n, bad, lim, blen;
        bit   ok;
        logic e0;
        tog_q.delete();
        busy_fell = 1'b0;
        @(negedge clk); #1;
        play = 1'b1;
        for (int k = 0; k < v.nbytes; k++) begin
            wait_ready(ok);
            if (!ok) return;
            if (k > 0 && v.underrun > 0) begin
                e0 = ear;
                n  = tog_q.size();
                wait_ce(v.underrun);
                chk($sformatf("v%0d_underrun_ear", idx), int'(ear), int'(e0));
                chk($sformatf("v%0d_underrun_toggles", idx), tog_q.size(), n);
            end
            if (v.coincide && k > 0) begin
                n = 0;
                while (!ce && n < 10) begin @(negedge clk); #1; n++; end
                chk($sformatf("v%0d_coincide_ce", idx), int'(ce), 1);
            end
            din       = v.b[k];
            din_last  = (k == v.nbytes - 1);
            din_valid = 1'b1;
            @(negedge clk);
            xt[k] = eff_cnt;
            chk($sformatf("v%0d_ready_drop%0d", idx, k), int'(din_ready), 0);
            #1;
            din_valid = 1'b0;
            din_last  = 1'b0;
            if (k == 0 && v.gap_len > 0) begin
                wait_ce(v.gap_at);
                play = 1'b0;
                e0   = ear;
                n    = tog_q.size();
                wait_ce(v.gap_len);
                chk($sformatf("v%0d_gap_ear", idx), int'(ear), int'(e0));
                chk($sformatf("v%0d_gap_toggles", idx), tog_q.size(), n);
                play = 1'b1;
            end
        end
        n = 0;
        while (!busy_fell && n < TMO) begin @(negedge clk); n++; end
        if (!busy_fell) begin
            checks++; errors++;
            $display("FAIL v%0d_busy_timeout: got BUSY=1 after %0d cycles, expected 0", idx, TMO);
            return;
        end
        // Expected pulse end times: every pulse measured from the transfer that started its run.
        t = xt[0];
        repeat (v.exp_pilot) begin t += P_PILOT; exp_q.push_back(t); end
        t += P_SYNC1; exp_q.push_back(t);
        t += P_SYNC2; exp_q.push_back(t);
        for (int k = 0; k < v.nbytes; k++) begin
            if (k > 0) t = xt[k];
            for (int i = 7; i >= 0; i--) begin
                blen = v.b[k][i] ? P_BIT1 : P_BIT0;
                repeat (2) begin t += blen; exp_q.push_back(t); end
            end
        end
        total = exp_q.size();
        // The last pulse forces EAR low; it shows as an edge only when EAR was high.
        exp_n = total - 1 + (((total - 1) % 2 == 1) ? 1 : 0);
        chk($sformatf("v%0d_toggle_count", idx), tog_q.size(), exp_n);
        lim = (tog_q.size() < exp_n) ? tog_q.size() : exp_n;
        bad = -1;
        for (int i = 0; i < lim; i++) begin
            if (bad < 0 && tog_q[i] != exp_q[i]) begin
                bad = i;
                $display("v%0d pulse %0d ends at %0d, model %0d", idx, i, tog_q[i], exp_q[i]);
            end
        end
        chk($sformatf("v%0d_first_bad_pulse", idx), bad, -1);
        chk($sformatf("v%0d_pause_len", idx), busy_fall_t - exp_q[total - 1], P_PAUSE);
        chk($sformatf("v%0d_ear_after", idx), int'(ear_at_fall), 0);
    endtask

    initial begin
        bit ok;
        int n;
        vecs[0] = mk(8'h00, 8'h03, 8'h00, 2, P_HDR, 0,  1'b0, 0,  0);
        vecs[1] = mk(8'hFF, 8'h00, 8'h00, 1, P_DAT, 0,  1'b0, 0,  0);
        vecs[2] = mk(8'h00, 8'hA5, 8'h00, 2, P_HDR, 50, 1'b0, 0,  0);
        vecs[3] = mk(8'h40, 8'h81, 8'h00, 2, P_HDR, 0,  1'b0, 10, 20);
        vecs[4] = mk(8'hFF, 8'h5A, 8'h00, 2, P_DAT, 0,  1'b1, 0,  0);
        vecs[5] = mk(8'h13, 8'hC4, 8'h7E, 3, P_HDR, 7,  1'b1, 0,  0);

        repeat (4) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ear", int'(ear), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_ready", int'(din_ready), 0);
        repeat (20) @(negedge clk);
        chk("idle_without_play", int'(busy), 0);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Reset in the middle of the data bits of a non-final byte.
        tog_q.delete();
        @(negedge clk); #1;
        play = 1'b1;
        wait_ready(ok);
        if (ok) begin
            din = 8'h00; din_last = 1'b0; din_valid = 1'b1;
            @(negedge clk); #1;
            din_valid = 1'b0;
            n = 0;
            while (tog_q.size() < P_HDR + 2 + 3 && n < TMO) begin @(negedge clk); n++; end
            chk("pre_reset_reached_data", int'(tog_q.size() >= P_HDR + 2 + 3), 1);
            #1 rst = 1'b1;
            #1;
            chk("mid_reset_ear", int'(ear), 0);
            chk("mid_reset_busy", int'(busy), 0);
            chk("mid_reset_ready", int'(din_ready), 0);
            repeat (3) @(negedge clk);
            #1 rst = 1'b0;
            n = 0;
            while (!din_ready && n < 10) begin @(negedge clk); #1; n++; end
            chk("restart_fetch0_ready", int'(din_ready), 1);
            repeat (2) @(negedge clk);
            run_vec(6, vecs[1]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
